keypad_scanner_4x4: RTL and testbench

//   Front end of the keypad path. Scans a 4x4 matrix keypad (active-low rows and columns) and debounces it.

---
 rtl/keypad_scanner_4x4_if.sv | 13 +
 rtl/keypad_scanner_4x4.sv | 100 ++++++++++
 tb/tb_keypad_scanner_4x4.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_4x4_if.sv
// keypad_scanner_4x4_if: keypad matrix lines plus debounced key outputs
//   col_in/row_out : keypad columns (in, pulled up) and active-low rows (out)
//   onehot/key_code/key_press/key_release : debounced key vector, index and pulses
interface keypad_scanner_4x4_if;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [15:0] onehot;
  logic [3:0]  key_code;
  logic        key_press;
  logic        key_release;
  modport master (input col_in, output row_out, onehot, key_code, key_press, key_release);
  modport slave (output col_in, input row_out, onehot, key_code, key_press, key_release);
endinterface

// File: rtl/keypad_scanner_4x4.sv
// keypad_scanner_4x4: scans and debounces a 4x4 active-low keypad into a one-hot key vector
//   clk, RST : clock and synchronous active-high reset
//   kp       : keypad rows/columns and debounced onehot, key_code, key_press, key_release
module keypad_scanner_4x4 #(
  parameter int SCAN_DIV        = 50_000,
  parameter int DEBOUNCE_FRAMES = 5
) (
  input logic clk,
  input logic RST,
  keypad_scanner_4x4_if.master kp
);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_FRAMES);
  typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;
  state_t state, state_n;
  logic [3:0] col_m, col_s, code_n;
  logic [SW-1:0] slot;
  logic [1:0] row;
  logic [15:0] frame, f, cand, cand_n, onehot_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic press_n, release_n, sample, frame_end, single;
  function automatic logic [3:0] idx(input logic [15:0] v);
    idx = '0;
    for (int i = 0; i < 16; i++) if (v[i]) idx = 4'(i);
  endfunction
  assign sample = slot == SLOT_LAST;
  assign frame_end = sample && row == 2'd3;
  // the row-3 sample lands in the frame on this same edge, so splice it in directly
  assign f = {~col_s, frame[11:0]};
  assign single = f != '0 && (f & (f - 16'd1)) == '0;
  assign cnt_inc = cnt == CNT_MAX ? cnt : cnt + 1'b1;
  assign kp.row_out = ~(4'b0001 << row);
  always_ff @(posedge clk) begin
    if (RST) begin
      col_m <= 4'hf;
      col_s <= 4'hf;
      slot <= '0;
      row <= '0;
      frame <= '0;
      state <= IDLE;
      cnt <= '0;
      cand <= '0;
      kp.onehot <= '0;
      kp.key_code <= '0;
      kp.key_press <= 1'b0;
      kp.key_release <= 1'b0;
    end else begin
      col_m <= kp.col_in;
      col_s <= col_m;
      slot <= sample ? '0 : slot + 1'b1;
      row <= sample ? row + 2'd1 : row;
      if (sample) frame[{row, 2'b00} +: 4] <= ~col_s;
      state <= state_n;
      cnt <= cnt_n;
      cand <= cand_n;
      kp.onehot <= onehot_n;
      kp.key_code <= code_n;
      kp.key_press <= press_n;
      kp.key_release <= release_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    cand_n = cand;
    onehot_n = kp.onehot;
    code_n = kp.key_code;
    press_n = 1'b0;
    release_n = 1'b0;
    if (frame_end)
      case (state)
        IDLE: if (single) begin
          state_n = PRESS;
          cand_n = f;
          cnt_n = CW'(1);
        end
        PRESS: if (f != cand) state_n = IDLE; else cnt_n = cnt_inc;
        HELD: if (f != kp.onehot) begin
          state_n = RELEASE;
          cnt_n = f == '0 ? CW'(1) : '0;
        end
        RELEASE: if (f == '0) cnt_n = cnt_inc; else if (f == kp.onehot) state_n = HELD; else cnt_n = '0;
        default: state_n = IDLE;
      endcase
    // completion is checked on the next-state values so a single-frame debounce finishes on entry
    if (state_n == PRESS && cnt_n >= CNT_MAX) begin
      state_n = HELD;
      onehot_n = cand_n;
      code_n = idx(cand_n);
      press_n = 1'b1;
    end
    if (state_n == RELEASE && cnt_n >= CNT_MAX) begin
      state_n = IDLE;
      onehot_n = '0;
      release_n = 1'b1;
    end
  end
endmodule

// File: tb/tb_keypad_scanner_4x4.sv
// tb_keypad_scanner_4x4: scoreboard bench for the keypad scanner with a shorting keypad model
module tb_keypad_scanner_4x4;
  typedef struct {logic rel; logic [15:0] oh; logic [3:0] code;} ev_t;
  logic clk = 1'b0;
  logic RST = 1'b1;
  logic [15:0] keys = '0;
  logic [3:0] cols;
  logic rst_q = 1'b1;
  logic prev_pulse = 1'b0;
  logic [15:0] prev_oh = '0;
  int cyc = 0;
  int pcyc = 0;
  int t0 = 0;
  int checks = 0;
  int errors = 0;
  ev_t q[$];
  ev_t e;
  keypad_scanner_4x4_if kif();
  keypad_scanner_4x4 #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (.clk(clk), .RST(RST), .kp(kif.master));
  always #5 clk = ~clk;
  always_comb begin
    cols = 4'hf;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!kif.row_out[r] && keys[r*4+c]) cols[c] = 1'b0;
  end
  assign kif.col_in = cols;
  always @(posedge clk) begin
    rst_q <= RST;
    cyc <= RST ? 0 : cyc + 1;
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, a, x);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_q) begin
      if (kif.key_press || kif.key_release) begin
        pcyc = cyc;
        chk("pulse_exclusive", {31'd0, kif.key_press & kif.key_release}, 0);
        chk("pulse_1cycle", {31'd0, prev_pulse}, 0);
        chk("pulse_onehot_change", {31'd0, kif.onehot != prev_oh}, 1);
        if (q.size() == 0) chk("unexpected_pulse", {14'd0, kif.key_press, kif.key_release, kif.onehot}, 0);
        else begin
          e = q.pop_front();
          chk("pulse_kind", {31'd0, kif.key_release}, {31'd0, e.rel});
          chk("onehot", {16'd0, kif.onehot}, e.rel ? 0 : {16'd0, e.oh});
          chk("key_code", {28'd0, kif.key_code}, {28'd0, e.code});
        end
      end else if (kif.onehot != prev_oh) chk("silent_onehot_change", {16'd0, kif.onehot}, {16'd0, prev_oh});
    end
    prev_oh = kif.onehot;
    prev_pulse = kif.key_press | kif.key_release;
  end
  task automatic push(input logic rel, input logic [15:0] oh, input logic [3:0] code);
    e.rel = rel;
    e.oh = oh;
    e.code = code;
    q.push_back(e);
  endtask
  task automatic frames(input int n);
    repeat (n * 16) @(negedge clk);
  endtask
  task automatic drain(input string n);
    int t = 0;
    while (q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk(n, q.size(), 0);
    q.delete();
  endtask
  task automatic align();
    while (cyc % 16 != 0) @(negedge clk);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    RST = 1'b0;
    chk("reset_onehot", {16'd0, kif.onehot}, 0);
    chk("reset_code", {28'd0, kif.key_code}, 0);
    chk("reset_pulses", {30'd0, kif.key_press, kif.key_release}, 0);
    for (int j = 0; j <= 16; j++) begin
      chk("row_out", {28'd0, kif.row_out}, {28'd0, ~(4'b0001 << ((j / 4) % 4))});
      @(negedge clk);
    end
    align();
    keys = 16'h0200;
    t0 = cyc;
    push(1'b0, 16'h0200, 4'd9);
    frames(6);
    drain("press_r2c1");
    chk("press_latency", pcyc - t0, 48);
    chk("held_r2c1", {16'd0, kif.onehot}, 32'h0200);
    align();
    keys = '0;
    t0 = cyc;
    push(1'b1, '0, 4'd9);
    frames(6);
    drain("release_r2c1");
    chk("release_latency", pcyc - t0, 48);
    for (int i = 0; i < 6; i++) begin
      keys = 16'h0008;
      frames(1);
      keys = '0;
      frames(1);
    end
    chk("bounce_onehot", {16'd0, kif.onehot}, 0);
    keys = 16'h0008;
    push(1'b0, 16'h0008, 4'd3);
    frames(6);
    drain("press_r0c3");
    keys = '0;
    push(1'b1, '0, 4'd3);
    frames(6);
    drain("release_r0c3");
    keys = 16'h0010;
    push(1'b0, 16'h0010, 4'd4);
    frames(6);
    drain("press_r1c0");
    keys = 16'h8010;
    frames(5);
    chk("no_rollover", {16'd0, kif.onehot}, 32'h0010);
    keys = '0;
    push(1'b1, '0, 4'd4);
    frames(6);
    drain("release_both");
    keys = 16'h8000;
    push(1'b0, 16'h8000, 4'd15);
    frames(6);
    drain("press_r3c3");
    keys = '0;
    push(1'b1, '0, 4'd15);
    frames(6);
    drain("release_r3c3");
    keys = 16'h0420;
    frames(10);
    chk("multi_onehot", {16'd0, kif.onehot}, 0);
    keys = '0;
    frames(4);
    chk("multi_after", {16'd0, kif.onehot}, 0);
    keys = 16'h0001;
    push(1'b0, 16'h0001, 4'd0);
    frames(6);
    drain("press_r0c0");
    RST = 1'b1;
    keys = '0;
    @(negedge clk);
    chk("midreset_onehot", {16'd0, kif.onehot}, 0);
    chk("midreset_row", {28'd0, kif.row_out}, 32'he);
    chk("midreset_pulses", {30'd0, kif.key_press, kif.key_release}, 0);
    RST = 1'b0;
    frames(6);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
